// File: rtl/uart_frame_rx_assembler_pkg.sv
// Shared types and limits for the UART frame receive assembler.
// State encoding, flag bit positions and parameter bounds.
package uart_frame_rx_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLAGS = 2'd2,
    ST_PUSH  = 2'd3
  } state_e;

  localparam int IS_WRITE_BIT   = 0;
  localparam int DATA_BYTES_MIN = 1;
  localparam int DATA_BYTES_MAX = 4;
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 16;

endpackage

// File: rtl/uart_frame_rx_assembler_fifo.sv
// First-word-fall-through synchronous FIFO for assembled frames.
// Head entry is visible on rdata; reads zero while empty.
module frame_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_frame_rx_assembler.sv
// Assembles UART bytes into {flags,data} frames and buffers them.
// Handles inter-byte timeout, FIFO overflow and loss counting.
module uart_frame_rx_assembler
  import uart_frame_rx_assembler_pkg::*;
#(
  parameter int DATA_BYTES     = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              uart_data_out,
  input  logic                    uart_ready,
  output logic                    uart_ready_clr,
  output logic [8*DATA_BYTES-1:0] frame_data,
  output logic [7:0]              frame_flags,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    err_timeout,
  output logic                    err_overflow,
  output logic [7:0]              drop_count
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e          state_q;
  state_e          state_d;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   data_q;
  logic [7:0]      flags_q;
  logic [TW-1:0]   tcnt_q;
  logic            cap;
  logic            last;
  logic            to_hit;
  logic            ovf;
  logic            push;
  logic [DW+7:0]   head;
  logic            f_full;
  logic            f_empty;
  logic [$clog2(FIFO_DEPTH):0] f_count;

  assign cap  = uart_ready && !uart_ready_clr
                && (state_q != ST_PUSH);
  assign last = (idx_q == IW'(DATA_BYTES - 1));
  assign push = (state_q == ST_PUSH);

  assign to_hit = TO_EN && !cap && (tcnt_q == T_LAST)
                  && ((state_q == ST_DATA) || (state_q == ST_FLAGS));
  assign ovf = push && f_full && !(frame_ready && !f_empty);

  assign frame_valid = (f_count != '0);
  assign frame_data  = head[DW-1:0];
  assign frame_flags = head[DW+7:DW];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (cap) state_d = (DATA_BYTES > 1) ? ST_DATA : ST_FLAGS;
      ST_DATA:
        if (cap && last) state_d = ST_FLAGS;
        else if (to_hit) state_d = ST_IDLE;
      ST_FLAGS:
        if (cap)         state_d = ST_PUSH;
        else if (to_hit) state_d = ST_IDLE;
      ST_PUSH:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q          <= '0;
      data_q         <= '0;
      flags_q        <= '0;
      uart_ready_clr <= 1'b0;
    end else begin
      uart_ready_clr <= cap;
      if (cap && state_q == ST_FLAGS) begin
        flags_q <= uart_data_out;
      end else if (cap) begin
        for (int b = 0; b < DATA_BYTES; b++)
          if (idx_q == IW'(b)) data_q[8*b +: 8] <= uart_data_out;
      end
      // Index only advances through data bytes; anything else rewinds it
      if (cap && (state_q == ST_IDLE || state_q == ST_DATA))
        idx_q <= last ? '0 : idx_q + 1'b1;
      else if (to_hit || state_q != ST_DATA)
        idx_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt_q <= '0;
    end else if (cap || to_hit || state_q == ST_IDLE
                 || state_q == ST_PUSH) begin
      tcnt_q <= '0;
    end else if (TO_EN) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      drop_count   <= '0;
    end else begin
      err_timeout  <= to_hit;
      err_overflow <= ovf;
      if ((to_hit || ovf) && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  frame_sync_fifo #(
    .WIDTH (DW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({flags_q, data_q}),
    .pop   (frame_ready),
    .rdata (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

endmodule

// File: doc/uart_frame_rx_assembler.md
UART_FRAME_RX_ASSEMBLER -- requirements
Module: uart_frame_rx_assembler

Interface
REQ-001 Param DATA_BYTES, default 1, number of data bytes per frame (1..4), sent little-endian.
REQ-002 Param FIFO_DEPTH, default 4, number of assembled-frame entries; a power of two, 2..16.
REQ-003 Param TIMEOUT_CYCLES, default 50000, inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-004 clk  in  1  single system clock; every flop is on its rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 uart_data_out  in  8  received UART byte.
REQ-007 uart_ready  in  1  level high while uart_data_out holds an unconsumed byte.
REQ-008 uart_ready_clr  out  1  one-cycle pulse that consumes the current byte.
REQ-009 frame_data  out  8*DATA_BYTES  FIFO head data; byte 0 is in bits [7:0].
REQ-010 frame_flags  out  8  FIFO head flags byte; bit 0 is is_write.
REQ-011 frame_valid  out  1  FIFO non-empty.
REQ-012 frame_ready  in  1  downstream accept.
REQ-013 err_timeout  out  1  one-cycle pulse when a partial frame is discarded on timeout.
REQ-014 err_overflow  out  1  one-cycle pulse when a complete frame is dropped because the FIFO is full.
REQ-015 drop_count  out  8  saturating count of frames lost to timeout or overflow.

Function
REQ-016 Wire frame format: DATA_BYTES data bytes, then one flags byte.
REQ-017 Byte capture condition: uart_ready=1 and uart_ready_clr=0 in the same cycle.
REQ-018 On each capture: store the byte, assert uart_ready_clr for exactly the next cycle.
REQ-019 States:
- IDLE: the first capture stores byte 0, then -> DATA if DATA_BYTES>1, else -> FLAGS.
- DATA: captures bytes 1..DATA_BYTES-1 via a byte index; the last one -> FLAGS.
- FLAGS: capture stores the flags byte -> PUSH.
- PUSH: for one cycle, write {flags,data} to the FIFO or drop it -> IDLE.
REQ-020 In PUSH with the FIFO full and no pop in that cycle: the frame is dropped, err_overflow pulses, and drop_count increments.
REQ-021 In PUSH with the FIFO full and a pop in the same cycle: the push is accepted.
REQ-022 FIFO is first-word-fall-through: frame_valid=(count!=0), and frame_data/frame_flags show the head entry.
REQ-023 A pop occurs when frame_valid && frame_ready; an empty FIFO ignores frame_ready.
REQ-024 Latency: flags captured at edge T; PUSH in cycle T+1; frame_valid=1 in cycle T+2 if the FIFO was empty.
REQ-025 Throughput: the FIFO accepts one frame per cycle and delivers one pop per cycle.
REQ-026 Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
REQ-027 The count is log2(FIFO_DEPTH)+1 bits wide; a push and pop in the same cycle leave it unchanged.
REQ-028 Timeout counter: cleared on every capture and in IDLE; increments in DATA and FLAGS.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES-1 with no capture in that cycle:
- the partial frame is discarded;
- err_timeout pulses;
- drop_count increments;
- the FSM returns to IDLE.
REQ-030 A capture in the same cycle as the timeout terminal count wins, and no timeout occurs.
REQ-031 drop_count saturates at 8'hFF.
REQ-032 A timeout and an overflow cannot occur in the same cycle, so each loss adds exactly 1.
REQ-033 No byte is captured while in PUSH; a pending uart_ready is taken in IDLE in the next cycle.

Reset
REQ-034 On rstn=0, immediately and asynchronously: state=IDLE, byte index=0, timeout counter=0, pointers=0, count=0.
REQ-035 Output reset values:
- uart_ready_clr=0;
- frame_valid=0;
- frame_data=0;
- frame_flags=0;
- err_timeout=0;
- err_overflow=0;
- drop_count=0.
REQ-036 FIFO storage is not reset; frame_data/frame_flags read 0 while the FIFO is empty.
REQ-037 A reset in mid-frame or with the FIFO non-empty discards all content; no frame is emitted after release.

Structure
REQ-038 Shared package holds: the state encoding (IDLE=0, DATA=1, FLAGS=2, PUSH=3), the flag bit index IS_WRITE_BIT=0, and the DATA_BYTES/FIFO_DEPTH limits.
REQ-039 One sub-module, frame_sync_fifo (parametrised width and depth, FWFT, full/empty/count), holds the frame buffer.
REQ-040 The assembler FSM, timeout counter and error logic stay in the top module.

Verification
REQ-041 DATA_BYTES=1: send 8'hA5, 8'h01 -> one frame, data=8'hA5, flags=8'h01, frame_valid 2 cycles after the flags capture.
REQ-042 DATA_BYTES=4: send 8'h11, 8'h22, 8'h33, 8'h44, 8'h00 -> data=32'h44332211, flags=8'h00.
REQ-043 TIMEOUT_CYCLES=20: send two bytes of a 4-byte frame, then idle -> err_timeout pulses once, drop_count=1, no frame; the next full frame is received correctly.
REQ-044 FIFO_DEPTH=4 with frame_ready=0: send 5 frames -> 4 frames buffered, err_overflow once, drop_count=1; then raise frame_ready -> frames 1..4 pop in order.
REQ-045 FIFO full with a pop in the same cycle as PUSH -> no overflow and count stays at 4.
REQ-046 Assert rstn=0 mid-frame and with 2 frames buffered -> frame_valid=0 and drop_count=0 immediately; the first frame after release is assembled from fresh bytes only.
